sort4_feeder: RTL

SORT4_FEEDER -- requirements
Module: sort4_feeder

---
 rtl/sort4_feeder.sv | 81 ++++++++
 1 files changed

// File: rtl/sort4_feeder.sv
// Serial-to-parallel frame builder for a four-input sorter: collects four
// samples into slots a..d, pads short frames on flush, and holds each frame until it is consumed.
//
// state  | meaning
// S_FILL | collecting samples into slot[fill]; din_ready = 1
// S_HOLD | complete frame presented on a..d; out_valid = 1
module sort4_feeder #(
  parameter int             W   = 4,
  parameter logic [W-1:0]   PAD = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic         flush,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic [W-1:0] d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [2:0]   fill
);

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]   state;
  logic [2:0]   fill_q;
  logic [W-1:0] slot [4];
  logic         accept;
  logic         last;
  logic         do_pad;
  logic [2:0]   pad_from;

  assign din_ready = (state == S_FILL) ? 1'b1 : out_ready;
  assign accept    = din_valid & din_ready;
  assign last      = (state == S_FILL) && accept && (fill_q == 3'd3);
  // A flush with nothing written and nothing arriving would make an empty frame.
  assign do_pad    = (state == S_FILL) && flush && !last && (accept || (fill_q != 3'd0));
  assign pad_from  = accept ? (fill_q + 3'd1) : fill_q;

  assign a         = slot[0];
  assign b         = slot[1];
  assign c         = slot[2];
  assign d         = slot[3];
  assign out_valid = (state == S_HOLD);
  assign fill      = fill_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_FILL;
      fill_q <= 3'd0;
      for (int i = 0; i < 4; i++) slot[i] <= '0;
    end else if (state == S_FILL) begin
      for (int i = 0; i < 4; i++) begin
        if (accept && (fill_q == 3'(i)))
          slot[i] <= din;
        else if (do_pad && (3'(i) >= pad_from))
          slot[i] <= PAD;
      end
      if (last || do_pad) begin
        fill_q <= 3'd4;
        state  <= S_HOLD;
      end else if (accept) begin
        fill_q <= fill_q + 3'd1;
      end
    end else if (out_ready) begin
      // Handshake edge may also start the next frame without a bubble.
      state <= S_FILL;
      if (din_valid) begin
        slot[0] <= din;
        fill_q  <= 3'd1;
      end else begin
        fill_q  <= 3'd0;
      end
    end
  end

endmodule
